apb_master_bridge: RTL and testbench

Converts a simple valid/ready command stream into APB4 transfers and returns one response per command. Sits directly upstream of the APB slave, driving paddr/psel/penable/pwrite/pwdata/pstrb and sampling prdata/pready/pslverr. Handles slave wait states and aborts a transfer that waits too long.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_master_bridge.sv | 120 ++++++++++++
 tb/tb_apb_master_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and width defaults for the APB master bridge.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // One upstream command at the default widths.
    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
    } cmd_t;

    // One downstream response at the default widths.
    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive stalled ACCESS cycles and flags the one that exhausts the budget.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Saturating count of stalled cycles, cleared whenever a new transfer starts.
    always_ff @(posedge pclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (preset || clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // expire marks the stalled cycle that would bring the count to the limit.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            assign expire = count_en && (count == LIMIT - 1'b1);
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Turns a valid/ready command stream into APB4 transfers, one response per command.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    state_e state;
    logic   timer_clear;
    logic   timer_en;
    logic   timer_expire;

    // Timer is cleared in SETUP and counts ACCESS cycles the slave stalls.
    assign timer_clear = (state == SETUP);
    assign timer_en    = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (timer_clear),
        .count_en(timer_en),
        .expire  (timer_expire)
    );

    // Transfer FSM; every output is a register updated alongside the state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        psel      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over an expiring timer in the same cycle.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        state       <= RESP;
                    end else if (timer_expire) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge with a transaction-level response model.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int SW = APB_STRB_WIDTH;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STRB_WIDTH    (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    int checks = 0;
    int errors = 0;
    int txn_id = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string s);
        return $sformatf("t%0d_%s", txn_id, s);
    endfunction

    // Response the command must produce, given how the slave behaves.
    function automatic rsp_t model_rsp(input cmd_t c, input int waits,
                                       input logic slv_err, input logic [DW-1:0] slv_rdata);
        rsp_t r;
        bit   timed_out;
        timed_out = (TO != 0) && (waits >= TO);
        r.timeout = timed_out;
        r.err     = timed_out || slv_err;
        r.rdata   = (timed_out || c.write) ? '0 : slv_rdata;
        return r;
    endfunction

    function automatic logic [63:0] ctrl_now();
        return 64'({psel, penable, cmd_ready, rsp_valid});
    endfunction

    function automatic logic [63:0] req_now();
        return 64'({paddr, pwrite, pwdata, pstrb});
    endfunction

    function automatic logic [63:0] req_exp(input cmd_t c);
        logic [SW-1:0] s;
        s = c.write ? c.strb : '0;
        return 64'({c.addr, c.write, c.wdata, s});
    endfunction

    function automatic logic [63:0] rsp_now();
        return 64'({rsp_rdata, rsp_err, rsp_timeout});
    endfunction

    function automatic void scramble_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_strb  = SW'($urandom);
    endfunction

    // Runs one command end to end; entered and left on a falling edge.
    task automatic run_cmd(input cmd_t c, input int waits, input logic slv_err,
                           input logic [DW-1:0] slv_rdata, input int rsp_hold,
                           input bit keep_valid);
        rsp_t exp;
        int   n_acc;
        bit   ok;
        txn_id++;
        exp   = model_rsp(c, waits, slv_err, slv_rdata);
        n_acc = exp.timeout ? TO : waits + 1;

        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check(tg("cmd_ready_wait"), 64'(ok), 64'(1));
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = keep_valid;
        scramble_cmd();

        // SETUP: psel leads penable by one cycle
        check(tg("setup_ctrl"), ctrl_now(), 64'(4'b1000));
        check(tg("setup_req"), req_now(), req_exp(c));
        @(posedge pclk);
        @(negedge pclk);

        for (int k = 0; k < n_acc; k++) begin
            check(tg("access_ctrl"), ctrl_now(), 64'(4'b1100));
            check(tg("access_req"), req_now(), req_exp(c));
            pready  = (k == waits);
            prdata  = (k == waits) ? slv_rdata : DW'($urandom);
            pslverr = (k == waits) ? slv_err : 1'($urandom);
            if (k == waits && c.write) prdata = DW'($urandom) | 1;
            @(posedge pclk);
            @(negedge pclk);
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        check(tg("resp_ctrl"), ctrl_now(), 64'(4'b0001));
        check(tg("resp_fields"), rsp_now(), 64'(exp));
        check(tg("resp_req_hold"), req_now(), req_exp(c));
        for (int h = 0; h < rsp_hold; h++) begin
            rsp_ready = 1'b0;
            @(posedge pclk);
            @(negedge pclk);
            check(tg("hold_ctrl"), ctrl_now(), 64'(4'b0001));
            check(tg("hold_fields"), rsp_now(), 64'(exp));
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check(tg("post_hs_ctrl"), ctrl_now(), 64'(4'b0010));
    endtask

    function automatic cmd_t mk_cmd(input logic w, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        c.strb  = s;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        bit   ok;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset_ctrl", ctrl_now(), 64'(0));
        check("reset_req", req_now(), 64'(0));
        check("reset_rsp", rsp_now(), 64'(0));
        preset = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        // directed cases
        run_cmd(mk_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF), 0, 1'b0, '0, 0, 1'b0);
        run_cmd(mk_cmd(1'b0, 8'h20, 32'hCAFEF00D, 4'hF), 3, 1'b0, 32'h12345678, 0, 1'b0);
        run_cmd(mk_cmd(1'b1, 8'h30, 32'h0BADC0DE, 4'h3), 1, 1'b1, '0, 0, 1'b0);
        run_cmd(mk_cmd(1'b0, 8'h40, 32'h11111111, 4'hF), 4, 1'b0, 32'hAAAA5555, 1, 1'b0);
        run_cmd(mk_cmd(1'b0, 8'h44, 32'h22222222, 4'hF), 3, 1'b0, 32'h5A5AA5A5, 0, 1'b0);
        run_cmd(mk_cmd(1'b1, 8'h48, 32'h33333333, 4'hC), 9, 1'b0, '0, 0, 1'b0);
        run_cmd(mk_cmd(1'b0, 8'h50, 32'h44444444, 4'h1), 2, 1'b1, 32'h87654321, 5, 1'b1);

        // reset while the slave is stalling in ACCESS
        txn_id++;
        c = mk_cmd(1'b1, 8'h60, 32'h60606060, 4'hF);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check(tg("rst_cmd_ready_wait"), 64'(ok), 64'(1));
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check(tg("rst_in_access"), ctrl_now(), 64'(4'b1100));
        preset = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check(tg("rst_ctrl"), ctrl_now(), 64'(0));
        @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            check(tg("rst_quiet"), 64'({psel, penable, rsp_valid}), 64'(0));
        end
        run_cmd(mk_cmd(1'b0, 8'h64, 32'h0, 4'hF), 1, 1'b0, 32'hFEEDFACE, 0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            c = mk_cmd(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
            run_cmd(c, int'($urandom_range(0, 6)), 1'($urandom), DW'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
